class_search_scheduler: RTL and testbench

- Sequences the associative-search pass of inference.
- After the encoder finishes a query hypervector, it walks class memory chunk by chunk for every active class, accumulating per-chunk Hamming distance from the popcount datapath.
- Tracks the minimum-distance class and hands the prediction downstream over a valid/ready handshake.
- Counts completed queries and raises a done flag.

---
 rtl/hd_search_pkg.sv | 33 +++
 rtl/hd_argmin_tracker.sv | 43 ++++
 rtl/class_search_scheduler.sv | 107 ++++++++++
 tb/tb_class_search_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_search_pkg.sv
// Shared constants, FSM state encoding and return-tag layout for the
// associative-search scheduler.
package hd_search_pkg;

  localparam int DHV_SIZE        = 4000;
  localparam int CHUNK_W         = 32;
  localparam int CHUNKS          = DHV_SIZE / CHUNK_W;
  localparam int NUM_CLASSES_MAX = 26;
  localparam int CLA_ADDR_WIDTH  = 13;
  localparam int DIST_W          = 12;
  localparam int NUM_QUERIES     = 250;
  localparam int CLS_W           = 5;
  localparam int CHK_W           = 7;
  localparam int CNT_W           = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic             last_chunk;
    logic             valid;
  } ret_tag_t;

  function automatic logic [CLS_W-1:0] clamp_classes(input logic [CLS_W-1:0] req);
    return (req > CLS_W'(NUM_CLASSES_MAX)) ? CLS_W'(NUM_CLASSES_MAX) : req;
  endfunction

endpackage

// File: rtl/hd_argmin_tracker.sv
// Accumulates per-chunk Hamming distance for each class and keeps the
// running minimum; ties keep the earlier (lower-index) class.
module hd_argmin_tracker
  import hd_search_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  ret_tag_t          tag,
  input  logic [5:0]        chunk_dist,
  output logic [CLS_W-1:0]  best_cls,
  output logic [DIST_W-1:0] best_dist
);

  logic [DIST_W-1:0] acc_p1;
  logic [DIST_W-1:0] total;

  assign total = acc_p1 + DIST_W'(chunk_dist);

  // Return stage: accumulate, and resolve the compare on each class's last chunk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_p1    <= '0;
      best_cls  <= '0;
      best_dist <= '0;
    end else if (clear) begin
      acc_p1    <= '0;
      best_cls  <= '0;
      best_dist <= '1;
    end else if (tag.valid) begin
      if (tag.last_chunk) begin
        acc_p1 <= '0;
        if (total < best_dist) begin
          best_dist <= total;
          best_cls  <= tag.cls;
        end
      end else begin
        acc_p1 <= total;
      end
    end
  end

endmodule

// File: rtl/class_search_scheduler.sv
// Walks class memory chunk by chunk for every active class, tracks the
// argmin class and hands the prediction downstream over valid/ready.
module class_search_scheduler
  import hd_search_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [4:0]                class_num,
  output logic [CLA_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_rd_en,
  input  logic [5:0]                chunk_dist,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [4:0]                result_class,
  output logic [DIST_W-1:0]         result_dist,
  output logic [8:0]                query_count,
  output logic                      out_done
);

  localparam logic [CHK_W-1:0] LAST_CHK  = CHK_W'(CHUNKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(NUM_QUERIES);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(NUM_QUERIES - 1);

  state_t           state, state_next;
  logic [CLS_W-1:0] cls, n_cls;
  logic [CHK_W-1:0] chk;
  logic             last_read;
  logic             accept;
  logic             handshake;
  ret_tag_t         tag_p0;

  assign accept    = (state == IDLE) && start;
  assign handshake = (state == RESULT) && result_ready;
  assign last_read = (cls == n_cls - 5'd1) && (chk == LAST_CHK);
  assign mem_addr  = CLA_ADDR_WIDTH'(cls) * CLA_ADDR_WIDTH'(CHUNKS) + CLA_ADDR_WIDTH'(chk);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = (clamp_classes(class_num) == '0) ? RESULT : ISSUE;
      ISSUE:  if (last_read) state_next = DRAIN;
      DRAIN:  state_next = RESULT;
      RESULT: if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en    = (state == ISSUE);
    busy         = (state != IDLE);
    result_valid = (state == RESULT);
  end

  // Issue stage: class/chunk address counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_cls <= '0;
      cls   <= '0;
      chk   <= '0;
    end else if (accept) begin
      n_cls <= clamp_classes(class_num);
      cls   <= '0;
      chk   <= '0;
    end else if (state == ISSUE) begin
      if (chk == LAST_CHK) begin
        chk <= '0;
        cls <= cls + 5'd1;
      end else begin
        chk <= chk + 7'd1;
      end
    end
  end

  // Tag stage: aligns class/last-chunk info with the 1-cycle memory return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tag_p0 <= '0;
    else          tag_p0 <= '{cls: cls, last_chunk: (chk == LAST_CHK), valid: (state == ISSUE)};
  end

  hd_argmin_tracker u_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (accept),
    .tag        (tag_p0),
    .chunk_dist (chunk_dist),
    .best_cls   (result_class),
    .best_dist  (result_dist)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      query_count <= '0;
      out_done    <= 1'b0;
    end else if (handshake) begin
      if (query_count != CNT_MAX) query_count <= query_count + 9'd1;
      if (query_count == CNT_PRE) out_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_class_search_scheduler.sv
// Directed bench for class_search_scheduler with a one-cycle-latency class
// memory model returning a fixed per-class chunk distance.
module tb_class_search_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  class_num;
  logic [12:0] mem_addr;
  logic        mem_rd_en;
  logic [5:0]  chunk_dist;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  result_class;
  logic [11:0] result_dist;
  logic [8:0]  query_count;
  logic        out_done;

  int checks = 0;
  int failures = 0;
  int cyc;
  int dist_tab [32];
  int reads_total = 0;
  int pass_reads = 0;
  int addr_err = 0;
  int last_addr = 0;
  logic prev_rd = 1'b0;

  always #5 clk = ~clk;

  class_search_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .class_num    (class_num),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .chunk_dist   (chunk_dist),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_dist  (result_dist),
    .query_count  (query_count),
    .out_done     (out_done)
  );

  // Memory model plus read-address monitor
  always @(posedge clk) begin
    prev_rd <= mem_rd_en;
    if (mem_rd_en) begin
      if (int'(mem_addr) != (prev_rd ? pass_reads : 0)) addr_err <= addr_err + 1;
      pass_reads  <= (prev_rd ? pass_reads : 0) + 1;
      reads_total <= reads_total + 1;
      last_addr   <= int'(mem_addr);
    end
    chunk_dist <= mem_rd_en ? 6'(dist_tab[int'(mem_addr) / 125]) : 6'h3f;
  end

  task automatic start_query(input logic [4:0] n);
    @(negedge clk);
    class_num = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid(input int limit);
    while (!result_valid && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!result_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid timeout after %0d cycles", cyc);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    class_num = '0;
    result_ready = 1'b0;
    foreach (dist_tab[i]) dist_tab[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, result_valid, mem_rd_en, out_done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {busy, result_valid, mem_rd_en, out_done});
    end
    checks++;
    if (mem_addr !== 13'd0 || query_count !== 9'd0) begin
      failures++;
      $display("FAIL reset_regs addr=%0d count=%0d want 0/0", mem_addr, query_count);
    end
    checks++;
    if (result_class !== 5'd0 || result_dist !== 12'd0) begin
      failures++;
      $display("FAIL reset_result class=%0d dist=%0d want 0/0", result_class, result_dist);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int r0, e0;
    dist_tab[0] = 8; dist_tab[1] = 2; dist_tab[2] = 5;
    r0 = reads_total; e0 = addr_err;
    start_query(5'd3);
    wait_valid(2000);
    checks++;
    if (cyc != 377) begin failures++; $display("FAIL basic_latency got=%0d want=377", cyc); end
    checks++;
    if (reads_total - r0 != 375 || addr_err != e0 || last_addr != 374) begin
      failures++;
      $display("FAIL basic_reads reads=%0d addr_err=%0d last=%0d want 375/0/374",
               reads_total - r0, addr_err - e0, last_addr);
    end
    checks++;
    if (result_class !== 5'd1 || result_dist !== 12'd250) begin
      failures++;
      $display("FAIL basic_result class=%0d dist=%0d want 1/250", result_class, result_dist);
    end
    handshake();
    checks++;
    if (query_count !== 9'd1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_handshake count=%0d busy=%b valid=%b want 1/0/0", query_count, busy, result_valid);
    end
  endtask

  task automatic test_tie();
    dist_tab[0] = 4; dist_tab[1] = 4;
    start_query(5'd2);
    wait_valid(2000);
    checks++;
    if (cyc != 252 || result_class !== 5'd0 || result_dist !== 12'd500) begin
      failures++;
      $display("FAIL tie cyc=%0d class=%0d dist=%0d want 252/0/500", cyc, result_class, result_dist);
    end
    handshake();
  endtask

  task automatic test_hold();
    int r0;
    dist_tab[0] = 1;
    start_query(5'd1);
    wait_valid(2000);
    checks++;
    if (cyc != 127 || result_dist !== 12'd125) begin
      failures++;
      $display("FAIL hold_first cyc=%0d dist=%0d want 127/125", cyc, result_dist);
    end
    r0 = reads_total;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b1;
      class_num = 5'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b1 || result_class !== 5'd0 ||
          result_dist !== 12'd125 || query_count !== 9'd2) begin
        failures++;
        $display("FAIL hold_stable cycle=%0d valid=%b busy=%b class=%0d dist=%0d count=%0d",
                 i, result_valid, busy, result_class, result_dist, query_count);
      end
    end
    checks++;
    if (reads_total != r0) begin failures++; $display("FAIL hold_no_reads got=%0d want=0", reads_total - r0); end
    handshake();
    checks++;
    if (query_count !== 9'd3 || busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release count=%0d busy=%b valid=%b want 3/0/0", query_count, busy, result_valid);
    end
  endtask

  task automatic test_zero_and_clamp();
    int r0;
    r0 = reads_total;
    start_query(5'd0);
    wait_valid(10);
    checks++;
    if (cyc != 1 || result_class !== 5'd0 || result_dist !== 12'hfff || reads_total != r0) begin
      failures++;
      $display("FAIL zero_classes cyc=%0d class=%0d dist=%0d reads=%0d want 1/0/4095/0",
               cyc, result_class, result_dist, reads_total - r0);
    end
    handshake();
    for (int i = 0; i < 32; i++) dist_tab[i] = (i == 17) ? 1 : 10;
    r0 = reads_total;
    start_query(5'd31);
    wait_valid(5000);
    checks++;
    if (cyc != 3252 || reads_total - r0 != 3250 || last_addr != 3249) begin
      failures++;
      $display("FAIL clamp_reads cyc=%0d reads=%0d last=%0d want 3252/3250/3249",
               cyc, reads_total - r0, last_addr);
    end
    checks++;
    if (result_class !== 5'd17 || result_dist !== 12'd125) begin
      failures++;
      $display("FAIL clamp_result class=%0d dist=%0d want 17/125", result_class, result_dist);
    end
    handshake();
    checks++;
    if (query_count !== 9'd5) begin failures++; $display("FAIL clamp_count got=%0d want=5", query_count); end
  endtask

  task automatic test_reset_mid();
    int guard, hi;
    dist_tab[0] = 8; dist_tab[1] = 2; dist_tab[2] = 5;
    start_query(5'd3);
    guard = 0;
    while (pass_reads < 100 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, result_valid, mem_rd_en, out_done} !== 4'b0000 || mem_addr !== 13'd0 || query_count !== 9'd0) begin
      failures++;
      $display("FAIL midreset_outputs flags=%b addr=%0d count=%0d reads=%0d want 0000/0/0",
               {busy, result_valid, mem_rd_en, out_done}, mem_addr, query_count, pass_reads);
    end
    @(negedge clk);
    reset_n = 1'b1;
    hi = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (result_valid || busy) hi++;
    end
    checks++;
    if (hi != 0) begin failures++; $display("FAIL midreset_quiet active_cycles=%0d want=0", hi); end
    start_query(5'd3);
    wait_valid(2000);
    checks++;
    if (cyc != 377 || result_class !== 5'd1 || result_dist !== 12'd250) begin
      failures++;
      $display("FAIL midreset_rerun cyc=%0d class=%0d dist=%0d want 377/1/250", cyc, result_class, result_dist);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    result_ready = 1'b1;
    for (int i = 2; i <= 251; i++) begin
      start_query(5'd0);
      @(posedge clk);
      #1;
      if (i == 249 || i == 250 || i == 251) begin
        checks++;
        if (query_count !== 9'((i > 250) ? 250 : i) || out_done !== (i >= 250)) begin
          failures++;
          $display("FAIL queries_%0d count=%0d done=%b want %0d/%b",
                   i, query_count, out_done, (i > 250) ? 250 : i, i >= 250);
        end
      end
    end
    result_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_hold();
    test_zero_and_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
